// File: rtl/irig_pkg.sv
// Shared definitions for the IRIG-B002 decoder.
// - sym_e   : classified symbol (0, 1, position marker P, invalid width)
// - state_e : frame FSM state (SEARCH for the double marker, LOCKED to a frame)
// - default pulse-width thresholds in clk cycles at 50 MHz
// - frame geometry and the marker-position helper
package irig_pkg;

  localparam int unsigned T_GLITCH_DEF  = 50000;
  localparam int unsigned T_01_DEF      = 175000;
  localparam int unsigned T_1P_DEF      = 325000;
  localparam int unsigned T_PMAX_DEF    = 450000;
  localparam int unsigned T_TIMEOUT_DEF = 750000;

  localparam int unsigned FRAME_LEN = 100;
  localparam int unsigned TS_W      = 64;
  localparam int unsigned TDATA_W   = FRAME_LEN + TS_W;
  localparam int unsigned POS_W     = 7;

  typedef enum logic [1:0] {
    SYM_0   = 2'd0,
    SYM_1   = 2'd1,
    SYM_P   = 2'd2,
    SYM_INV = 2'd3
  } sym_e;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Position markers P1..P9 sit at 9, 19, ..., 99; position 0 is the
  // reference marker Pr that starts the frame.
  function automatic logic is_marker_pos(input logic [POS_W-1:0] pos);
    return (pos % 7'd10) == 7'd9;
  endfunction

endpackage

// File: rtl/b002_decoder_if.sv
// Single-beat AXI4-Stream output channel of the IRIG-B002 decoder.
// - tdata  : [63:0] Pr timestamp, [163:64] frame bits (bit 64+k = symbol k)
// - tvalid : beat available
// - tready : sink can accept
// - tlast  : always equal to tvalid (one beat per packet)
// Handshake: a beat transfers on a rising clk edge where tvalid & tready are
// both high; once tvalid is raised it stays high with tdata/tlast stable until
// that transfer, and tvalid never depends on tready.
interface b002_decoder_if;

  logic [irig_pkg::TDATA_W-1:0] tdata;
  logic                         tvalid;
  logic                         tready;
  logic                         tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/irig_symbol_classifier.sv
// Symbol front end for the IRIG-B002 decoder.
// Synchronizes irig_in, finds its edges, measures each high pulse and
// classifies it on the falling edge.
// Ports:
//   clk, aresetn : clock, synchronous active-low reset
//   counter_in   : free-running timestamp, latched at each synchronized rise
//   irig_in      : asynchronous IRIG level input
//   rise_stb     : one-cycle strobe on every synchronized rising edge
//   sym_valid    : one-cycle strobe, a non-glitch pulse has been classified
//   sym          : symbol class, valid with sym_valid
//   sym_ts       : counter_in captured at that pulse's rising edge
module irig_symbol_classifier
  import irig_pkg::*;
#(
  parameter int unsigned T_GLITCH = T_GLITCH_DEF,
  parameter int unsigned T_01     = T_01_DEF,
  parameter int unsigned T_1P     = T_1P_DEF,
  parameter int unsigned T_PMAX   = T_PMAX_DEF
) (
  input  logic            clk,
  input  logic            aresetn,
  input  logic [TS_W-1:0] counter_in,
  input  logic            irig_in,
  output logic            rise_stb,
  output logic            sym_valid,
  output sym_e            sym,
  output logic [TS_W-1:0] sym_ts
);

  localparam int unsigned W_W = $clog2(T_PMAX + 2);
  localparam logic [W_W-1:0] W_GLITCH = W_W'(T_GLITCH);
  localparam logic [W_W-1:0] W_01     = W_W'(T_01);
  localparam logic [W_W-1:0] W_1P     = W_W'(T_1P);
  localparam logic [W_W-1:0] W_PMAX   = W_W'(T_PMAX);
  localparam logic [W_W-1:0] W_SAT    = W_W'(T_PMAX + 1);

  logic            sync1_q, sync2_q, sync_d_q;
  logic            rise, fall, glitch;
  logic [W_W-1:0]  width_q;
  logic [TS_W-1:0] ts_tmp_q, ts_bak_q;
  sym_e            sym_c;

  assign rise     = sync2_q & ~sync_d_q;
  assign fall     = ~sync2_q & sync_d_q;
  assign glitch   = width_q < W_GLITCH;
  assign rise_stb = rise;

  always_comb begin
    sym_c = SYM_INV;
    if (width_q < W_01) begin
      sym_c = SYM_0;
    end else if (width_q < W_1P) begin
      sym_c = SYM_1;
    end else if (width_q <= W_PMAX) begin
      sym_c = SYM_P;
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      sync_d_q  <= 1'b0;
      width_q   <= '0;
      ts_tmp_q  <= '0;
      ts_bak_q  <= '0;
      sym_valid <= 1'b0;
      sym       <= SYM_0;
      sym_ts    <= '0;
    end else begin
      sync1_q  <= irig_in;
      sync2_q  <= sync1_q;
      sync_d_q <= sync2_q;

      // The rise cycle is the first high cycle, so the count starts at 1
      // and equals the number of synchronized high cycles at the fall.
      if (rise) begin
        width_q <= W_W'(1);
      end else if (sync2_q && (width_q != W_SAT)) begin
        width_q <= width_q + W_W'(1);
      end

      // A glitch must not disturb the timestamp of the last real rise,
      // so the previous capture is kept aside and restored.
      if (rise) begin
        ts_tmp_q <= counter_in;
        ts_bak_q <= ts_tmp_q;
      end else if (fall && glitch) begin
        ts_tmp_q <= ts_bak_q;
      end

      sym_valid <= fall & ~glitch;
      if (fall && !glitch) begin
        sym    <= sym_c;
        sym_ts <= ts_tmp_q;
      end
    end
  end

endmodule

// File: rtl/b002_decoder.sv
// IRIG-B002 time-code decoder.
// Aligns classified symbols to 100-symbol frames on the P9/Pr double marker,
// collects the frame bits and emits one AXI4-Stream beat per complete frame.
// Ports:
//   clk, aresetn : 50 MHz clock, synchronous active-low reset
//   counter_in   : free-running 64-bit timestamp counter
//   irig_in      : asynchronous IRIG-B002 level input
//   m_axis       : output stream, tdata = {frame_bits[99:0], pr_timestamp[63:0]}
//   dbg_state    : current frame FSM state
// Stream handshake: the beat transfers on a clk edge with tvalid & tready;
// tvalid/tdata are held stable until then. A frame finishing while a beat is
// still pending is dropped. tready never affects decoding.
module b002_decoder
  import irig_pkg::*;
#(
  parameter int unsigned T_GLITCH  = T_GLITCH_DEF,
  parameter int unsigned T_01      = T_01_DEF,
  parameter int unsigned T_1P      = T_1P_DEF,
  parameter int unsigned T_PMAX    = T_PMAX_DEF,
  parameter int unsigned T_TIMEOUT = T_TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            aresetn,
  input  logic [TS_W-1:0] counter_in,
  input  logic            irig_in,
  b002_decoder_if.master  m_axis,
  output state_e          dbg_state
);

  localparam int unsigned G_W = $clog2(T_TIMEOUT + 1);
  localparam logic [G_W-1:0]   G_SAT    = G_W'(T_TIMEOUT);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(FRAME_LEN - 1);

  logic            rise_stb;
  logic            sym_valid;
  sym_e            sym;
  logic [TS_W-1:0] sym_ts;

  irig_symbol_classifier #(
    .T_GLITCH (T_GLITCH),
    .T_01     (T_01),
    .T_1P     (T_1P),
    .T_PMAX   (T_PMAX)
  ) u_classifier (
    .clk        (clk),
    .aresetn    (aresetn),
    .counter_in (counter_in),
    .irig_in    (irig_in),
    .rise_stb   (rise_stb),
    .sym_valid  (sym_valid),
    .sym        (sym),
    .sym_ts     (sym_ts)
  );

  state_e                 state_q, state_d;
  logic                   prev_p_q, prev_p_d;
  logic [POS_W-1:0]       pos_q, pos_d, next_pos;
  logic [FRAME_LEN-1:0]   bits_q, bits_d;
  logic [TS_W-1:0]        ts_q, ts_d;
  logic [G_W-1:0]         gap_q, gap_d;
  logic                   done_q, done_d;
  logic                   tvalid_q;
  logic [TDATA_W-1:0]     tdata_q;

  assign next_pos  = pos_q + POS_W'(1);
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q  <= SEARCH;
      prev_p_q <= 1'b0;
      pos_q    <= '0;
      bits_q   <= '0;
      ts_q     <= '0;
      gap_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_p_q <= prev_p_d;
      pos_q    <= pos_d;
      bits_q   <= bits_d;
      ts_q     <= ts_d;
      gap_q    <= gap_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    prev_p_d = prev_p_q;
    pos_d    = pos_q;
    bits_d   = bits_q;
    ts_d     = ts_q;
    done_d   = 1'b0;
    gap_d    = gap_q;

    // Rise-to-rise gap, saturating so a dead input stays timed out.
    if (rise_stb) begin
      gap_d = '0;
    end else if (gap_q != G_SAT) begin
      gap_d = gap_q + G_W'(1);
    end

    case (state_q)
      SEARCH: begin
        if (sym_valid) begin
          if ((sym == SYM_P) && prev_p_q) begin
            state_d  = LOCKED;
            prev_p_d = 1'b0;
            pos_d    = '0;
            bits_d   = '0;
            ts_d     = sym_ts;
          end else begin
            prev_p_d = (sym == SYM_P);
          end
        end
      end

      LOCKED: begin
        if (sym_valid) begin
          if (pos_q == LAST_POS) begin
            // After P9 only a Pr may follow; it opens the next frame.
            if (sym == SYM_P) begin
              pos_d  = '0;
              bits_d = '0;
              ts_d   = sym_ts;
            end else begin
              state_d  = SEARCH;
              prev_p_d = 1'b0;
            end
          end else if (sym == SYM_INV) begin
            state_d  = SEARCH;
            prev_p_d = 1'b0;
          end else if (is_marker_pos(next_pos)) begin
            if (sym == SYM_P) begin
              pos_d            = next_pos;
              bits_d[next_pos] = 1'b0;
              done_d           = (next_pos == LAST_POS);
            end else begin
              state_d  = SEARCH;
              prev_p_d = 1'b0;
            end
          end else if (sym == SYM_P) begin
            // A stray P may itself be the first half of a real P9/Pr pair.
            state_d  = SEARCH;
            prev_p_d = 1'b1;
          end else begin
            pos_d            = next_pos;
            bits_d[next_pos] = (sym == SYM_1);
          end
        end else if (gap_q == G_SAT) begin
          state_d  = SEARCH;
          prev_p_d = 1'b0;
        end
      end

      default: begin
        state_d  = SEARCH;
        prev_p_d = 1'b0;
      end
    endcase
  end

  // Output register: a completed frame is loaded when no beat is pending
  // (or the pending one transfers this cycle); otherwise it is dropped.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
    end else begin
      if (done_q && (!tvalid_q || m_axis.tready)) begin
        tvalid_q <= 1'b1;
        tdata_q  <= {bits_q, ts_q};
      end else if (tvalid_q && m_axis.tready) begin
        tvalid_q <= 1'b0;
      end
    end
  end

  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tlast  = tvalid_q;

endmodule

// File: tb/tb_b002_decoder.sv
// Bench for b002_decoder with shortened pulse-width thresholds so whole
// frames fit in a short run. Symbol widths: 0 -> 8, 1 -> 17, P -> 26 cycles,
// symbol period 41 cycles.
module tb_b002_decoder;
  import irig_pkg::*;

  localparam int unsigned TG  = 5;
  localparam int unsigned T01 = 12;
  localparam int unsigned T1P = 22;
  localparam int unsigned TPM = 30;
  localparam int unsigned TTO = 50;
  localparam int unsigned PERIOD = 40;
  localparam int W0 = 8;
  localparam int W1 = 17;
  localparam int WP = 26;
  localparam int K0 = 0;
  localparam int K1 = 1;
  localparam int KP = 2;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        irig_in = 1'b0;
  logic [63:0] counter = 64'd1000;
  state_e      dbg_state;

  b002_decoder_if m_axis ();

  b002_decoder #(
    .T_GLITCH  (TG),
    .T_01      (T01),
    .T_1P      (T1P),
    .T_PMAX    (TPM),
    .T_TIMEOUT (TTO)
  ) dut (
    .clk        (clk),
    .aresetn    (aresetn),
    .counter_in (counter),
    .irig_in    (irig_in),
    .m_axis     (m_axis),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) counter <= counter + 64'd1;

  // ---------------- scoreboard state ----------------
  int             checks = 0;
  int             failures = 0;
  logic [163:0]   exp_q[$];
  logic [99:0]    ones_a, ones_b, ones_c;
  logic           held_v = 1'b0;
  logic [163:0]   held_d = '0;

  task automatic check(input string name, input logic [163:0] act, input logic [163:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Returns the counter value the DUT latches: the synchronizer delays the
  // rise by two clocks relative to the cycle irig_in was driven.
  task automatic send_sym(input int kind, output logic [63:0] ts);
    int w;
    w = (kind == KP) ? WP : ((kind == K1) ? W1 : W0);
    @(negedge clk);
    irig_in = 1'b1;
    ts = counter + 64'd2;
    repeat (w) @(negedge clk);
    irig_in = 1'b0;
    repeat (PERIOD - w) @(negedge clk);
  endtask

  // Positions 1..upto of a frame after its Pr. The expected beat is queued
  // before P9 is sent because the beat appears while P9 is still low.
  task automatic send_frame(input logic [99:0] ones, input logic push,
                            input logic [63:0] ts_pr, input int upto);
    logic [63:0] dummy;
    for (int p = 1; p <= upto; p++) begin
      if ((p == 99) && push) exp_q.push_back({ones, ts_pr});
      if ((p % 10) == 9) send_sym(KP, dummy);
      else               send_sym(ones[p] ? K1 : K0, dummy);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [163:0] exp_v;
    if (!aresetn) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        check("held_tvalid", {163'd0, m_axis.tvalid}, 164'd1);
        check("held_tdata", m_axis.tdata, held_d);
      end
      if (m_axis.tvalid && m_axis.tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=%h required=none", m_axis.tdata);
        end else begin
          exp_v = exp_q.pop_front();
          check("beat_tdata", m_axis.tdata, exp_v);
          check("beat_tlast", {163'd0, m_axis.tlast}, 164'd1);
        end
      end
      held_v = m_axis.tvalid && !m_axis.tready;
      held_d = m_axis.tdata;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] ts_a, ts_b, ts_d, dummy;
    int one_pos_a[12] = '{2, 3, 7, 12, 20, 21, 22, 25, 30, 33, 36, 37};

    // 26 s, 4 min, 17 h, day 69 in BCD
    ones_a = '0;
    foreach (one_pos_a[i]) ones_a[one_pos_a[i]] = 1'b1;
    ones_b = '0;
    ones_b[1] = 1'b1; ones_b[4] = 1'b1; ones_b[6] = 1'b1;
    ones_b[8] = 1'b1; ones_b[10] = 1'b1; ones_b[13] = 1'b1;
    ones_c = '0;
    ones_c[2] = 1'b1;

    m_axis.tready = 1'b1;

    // Reset
    aresetn = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_tvalid", {163'd0, m_axis.tvalid}, 164'd0);
    check("rst_tdata", m_axis.tdata, 164'd0);
    check("rst_tlast", {163'd0, m_axis.tlast}, 164'd0);
    check("rst_state", {163'd0, dbg_state}, {163'd0, SEARCH});
    aresetn = 1'b1;
    repeat (3) @(negedge clk);

    // Glitch: one-cycle pulse
    irig_in = 1'b1;
    @(negedge clk);
    irig_in = 1'b0;
    repeat (20) @(negedge clk);
    check("glitch_tvalid", {163'd0, m_axis.tvalid}, 164'd0);
    check("glitch_state", {163'd0, dbg_state}, {163'd0, SEARCH});

    // Full frame A after "000pp"
    send_sym(K0, dummy);
    send_sym(K0, dummy);
    send_sym(K0, dummy);
    check("pre_pr_state", {163'd0, dbg_state}, {163'd0, SEARCH});
    send_sym(KP, dummy);
    send_sym(KP, ts_a);
    check("lock_state", {163'd0, dbg_state}, {163'd0, LOCKED});
    send_frame(ones_a, 1'b1, ts_a, 99);
    check("a_beats_left", 164'(exp_q.size()), 164'd0);

    // New Pr then a partial frame, then silence
    send_sym(KP, dummy);
    check("relock_state", {163'd0, dbg_state}, {163'd0, LOCKED});
    send_frame(ones_a, 1'b0, 64'd0, 24);
    repeat (100) @(negedge clk);
    check("timeout_state", {163'd0, dbg_state}, {163'd0, SEARCH});
    check("partial_tvalid", {163'd0, m_axis.tvalid}, 164'd0);

    // Backpressure: frame B completes, frame C completes while B pending
    m_axis.tready = 1'b0;
    send_sym(KP, dummy);
    send_sym(KP, ts_b);
    send_frame(ones_b, 1'b1, ts_b, 99);
    send_sym(KP, dummy);
    send_frame(ones_c, 1'b0, 64'd0, 99);
    repeat (100) @(negedge clk);
    check("bp_tvalid", {163'd0, m_axis.tvalid}, 164'd1);
    check("bp_tdata", m_axis.tdata, {ones_b, ts_b});
    check("bp_tlast", {163'd0, m_axis.tlast}, 164'd1);
    @(posedge clk);
    #1 m_axis.tready = 1'b1;
    @(posedge clk);
    #1 m_axis.tready = 1'b0;
    @(negedge clk);
    check("bp_drained_tvalid", {163'd0, m_axis.tvalid}, 164'd0);
    check("bp_beats_left", 164'(exp_q.size()), 164'd0);
    m_axis.tready = 1'b1;
    repeat (5) @(negedge clk);

    // Resync: misplaced P at pos 5, then a clean "pp" and full frame
    send_sym(KP, dummy);
    send_sym(KP, dummy);
    for (int p = 1; p <= 4; p++) send_sym(K0, dummy);
    send_sym(KP, dummy);
    check("misplaced_state", {163'd0, dbg_state}, {163'd0, SEARCH});
    send_sym(K0, dummy);
    send_sym(K0, dummy);
    send_sym(KP, dummy);
    send_sym(KP, ts_d);
    send_frame(ones_a, 1'b1, ts_d, 99);
    repeat (100) @(negedge clk);
    check("final_beats_left", 164'(exp_q.size()), 164'd0);
    check("final_tvalid", {163'd0, m_axis.tvalid}, 164'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
